// File: rtl/seq_player_if.sv
// seq_player_if: control, timing and display signals between the game controller and seq_player
//   master (controller/checker side): drives start_i, new_seq_i, level_i, abort_i, tick_i, rd_idx_i
//   slave  (seq_player side): drives rd_pat_o, leds_o, idx_o, busy_o, done_o
interface seq_player_if #(
  parameter int MAX_LEN = 8
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  logic          start_i;
  logic          new_seq_i;
  logic [3:0]    level_i;
  logic          abort_i;
  logic          tick_i;
  logic [AW-1:0] rd_idx_i;
  logic [7:0]    rd_pat_o;
  logic [7:0]    leds_o;
  logic [AW-1:0] idx_o;
  logic          busy_o;
  logic          done_o;
  modport master (
    output start_i, new_seq_i, level_i, abort_i, tick_i, rd_idx_i,
    input  rd_pat_o, leds_o, idx_o, busy_o, done_o
  );
  modport slave (
    input  start_i, new_seq_i, level_i, abort_i, tick_i, rd_idx_i,
    output rd_pat_o, leds_o, idx_o, busy_o, done_o
  );
endinterface

// File: rtl/seq_player.sv
// seq_player: generates an LFSR pattern sequence and plays it step by step on the LEDs
//   CLK      game clock
//   RST      asynchronous active-low reset
//   bus      seq_player_if.slave: start/new_seq/level/abort/tick requests, checker read port
//            (rd_idx_i -> rd_pat_o, combinational), leds_o/idx_o display, busy_o, done_o pulse
module seq_player #(
  parameter int         MAX_LEN   = 8,
  parameter int         ON_TICKS  = 4,
  parameter int         OFF_TICKS = 2,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic         CLK,
  input  logic         RST,
  seq_player_if.slave  bus
);
  localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CW   = $clog2(TMAX + 1);
  typedef enum logic [2:0] {IDLE, GEN, SHOW, GAP, FIN} state_t;
  state_t        state_q;
  logic [7:0]    mem_q [MAX_LEN];
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    leds_q;
  logic [AW-1:0] idx_q, len_m1_q, len_m1_d, wptr_q;
  logic [CW-1:0] tcnt_q;
  logic          busy_q, done_q;
  // len is kept as len-1 so it fits the index width even when LEVEL clamps to MAX_LEN
  always_comb begin
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    len_m1_d = (bus.level_i == 4'd0)          ? '0 :
               (int'(bus.level_i) > MAX_LEN)  ? AW'(MAX_LEN - 1) :
                                                AW'(bus.level_i - 4'd1);
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
      lfsr_q   <= SEED;
      leds_q   <= '0;
      idx_q    <= '0;
      len_m1_q <= '0;
      wptr_q   <= '0;
      tcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.abort_i) begin
      state_q <= IDLE;
      leds_q  <= '0;
      tcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start_i) begin
          len_m1_q <= len_m1_d;
          idx_q    <= '0;
          wptr_q   <= '0;
          tcnt_q   <= '0;
          busy_q   <= 1'b1;
          state_q  <= bus.new_seq_i ? GEN : SHOW;
          leds_q   <= bus.new_seq_i ? 8'h00 : mem_q[0];
        end
        GEN: begin
          mem_q[wptr_q] <= lfsr_q;
          lfsr_q        <= lfsr_d;
          wptr_q        <= wptr_q + 1'b1;
          // mem[0] was written on the first GEN clock, so it is already stable here
          if (wptr_q == AW'(MAX_LEN - 1)) begin
            state_q <= SHOW;
            leds_q  <= mem_q[0];
          end
        end
        SHOW: if (bus.tick_i) begin
          tcnt_q <= tcnt_q + 1'b1;
          if (tcnt_q == CW'(ON_TICKS - 1)) begin
            state_q <= GAP;
            leds_q  <= '0;
            tcnt_q  <= '0;
          end
        end
        GAP: if (bus.tick_i) begin
          tcnt_q <= tcnt_q + 1'b1;
          if (tcnt_q == CW'(OFF_TICKS - 1)) begin
            tcnt_q <= '0;
            if (idx_q == len_m1_q) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHOW;
              idx_q   <= idx_q + 1'b1;
              leds_q  <= mem_q[idx_q + 1'b1];
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.rd_pat_o = mem_q[bus.rd_idx_i];
  assign bus.leds_o   = leds_q;
  assign bus.idx_o    = idx_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: randomized scoreboard bench for seq_player against a sequence-level reference model
module tb_seq_player;
  localparam int MAX_LEN = 8;
  localparam int ON      = 4;
  localparam int OFF     = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  seq_player_if #(.MAX_LEN(MAX_LEN)) bus ();
  seq_player #(.MAX_LEN(MAX_LEN), .ON_TICKS(ON), .OFF_TICKS(OFF), .SEED(8'hA5)) dut (
    .CLK(clk), .RST(rst_n), .bus(bus)
  );
  typedef struct {
    bit         is_done;
    logic [7:0] pat;
    logic [2:0] idx;
  } exp_t;
  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_mem [MAX_LEN];
  logic [7:0] m_lfsr;
  bit         tick_fixed = 1'b1;
  int         tick_ph = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
  // tick source: every 4th clock at first, random density later
  always @(negedge clk) begin
    if (tick_fixed) begin
      tick_ph     = (tick_ph + 1) % 4;
      bus.tick_i  = (tick_ph == 0);
    end else
      bus.tick_i = ($urandom_range(0, 2) == 0);
  end
  // monitor: pops the scoreboard on every new pattern shown and every DONE rise, and times ON/OFF phases in ticks
  logic [7:0] p_leds = '0;
  bit         p_done = 1'b0;
  bit         in_gap = 1'b0;
  bit         done_fall = 1'b0;
  int         tcnt = 0;
  task automatic pop_cmp(input bit d);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: leds 0x%0h idx %0d, nothing expected", d ? "done" : "step", bus.leds_o, bus.idx_o);
      return;
    end
    e = exp_q.pop_front();
    chk(d ? "kind_done" : "kind_step", 32'(e.is_done), 32'(d));
    chk("leds", 32'(bus.leds_o), 32'(e.pat));
    chk("idx", 32'(bus.idx_o), 32'(e.idx));
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      p_leds = '0; p_done = 1'b0; in_gap = 1'b0; done_fall = 1'b0; tcnt = 0;
    end else begin
      if (bus.tick_i) tcnt++;
      if (done_fall) begin
        chk("done_one_cycle", {30'd0, bus.done_o, bus.busy_o}, 32'd0);
        done_fall = 1'b0;
      end
      if (!bus.busy_o) in_gap = 1'b0;
      if (bus.leds_o != p_leds && bus.leds_o != 8'h00) begin
        if (in_gap) chk("gap_ticks", tcnt, OFF);
        pop_cmp(1'b0);
        tcnt = 0;
        in_gap = 1'b0;
      end else if (bus.leds_o == 8'h00 && p_leds != 8'h00) begin
        if (bus.busy_o) begin
          chk("on_ticks", tcnt, ON);
          in_gap = 1'b1;
        end
        tcnt = 0;
      end
      if (bus.done_o && !p_done) begin
        chk("fin_gap_ticks", in_gap ? tcnt : -1, OFF);
        chk("busy_at_done", 32'(bus.busy_o), 32'd1);
        pop_cmp(1'b1);
        done_fall = 1'b1;
        in_gap = 1'b0;
      end
      p_leds = bus.leds_o;
      p_done = bus.done_o;
    end
  end
  task automatic model_start(input bit ns, input int lvl);
    int len;
    len = (lvl == 0) ? 1 : (lvl > MAX_LEN) ? MAX_LEN : lvl;
    if (ns)
      for (int i = 0; i < MAX_LEN; i++) begin
        m_mem[i] = m_lfsr;
        m_lfsr   = lfsr_next(m_lfsr);
      end
    for (int i = 0; i < len; i++) exp_q.push_back('{is_done: 1'b0, pat: m_mem[i], idx: 3'(i)});
    exp_q.push_back('{is_done: 1'b1, pat: 8'h00, idx: 3'(len - 1)});
  endtask
  task automatic issue_start(input bit ns, input int lvl);
    logic [7:0] old0;
    int n;
    old0 = m_mem[0];
    @(negedge clk);
    bus.start_i = 1'b1; bus.new_seq_i = ns; bus.level_i = 4'(lvl); bus.rd_idx_i = '0;
    model_start(ns, lvl);
    @(negedge clk);
    bus.start_i = 1'b0; bus.new_seq_i = 1'($urandom); bus.level_i = 4'($urandom);
    chk("busy_rise", 32'(bus.busy_o), 32'd1);
    if (ns) begin
      chk("rd_during_gen", 32'(bus.rd_pat_o), 32'(old0));
      n = 0;
      while (bus.leds_o == 8'h00 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("gen_clocks", n, MAX_LEN);
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(bus.busy_o), 32'd0);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  task automatic wait_show(input int i);
    int n = 0;
    while (!(bus.idx_o == 3'(i) && bus.leds_o != 8'h00) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_show", 32'(bus.idx_o == 3'(i) && bus.leds_o != 8'h00), 32'd1);
  endtask
  task automatic sweep_rd(input string name);
    for (int i = 0; i < MAX_LEN; i++) begin
      bus.rd_idx_i = 3'(i);
      #1;
      chk(name, 32'(bus.rd_pat_o), 32'(m_mem[i]));
    end
  endtask
  logic [7:0] golden [4] = '{8'hA5, 8'h4A, 8'h95, 8'h2A};
  initial begin
    int n;
    bus.start_i = 1'b0; bus.new_seq_i = 1'b0; bus.level_i = '0; bus.abort_i = 1'b0; bus.rd_idx_i = '0;
    m_lfsr = 8'hA5;
    for (int i = 0; i < MAX_LEN; i++) m_mem[i] = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_leds", 32'(bus.leds_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_idx", 32'(bus.idx_o), 32'd0);
    chk("rst_rd", 32'(bus.rd_pat_o), 32'd0);
    rst_n = 1'b1;
    // first generated run, LEVEL 3, fixed tick spacing
    issue_start(1'b1, 3);
    wait_idle();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rd_idx_i = 3'(i);
      #1;
      chk("rd_first_seq", 32'(bus.rd_pat_o), 32'(golden[i]));
    end
    sweep_rd("rd_after_gen");
    // replay with LEVEL 0 plays one step, then regenerate continues the LFSR
    issue_start(1'b0, 0);
    wait_idle();
    issue_start(1'b1, 2);
    wait_idle();
    sweep_rd("rd_regen");
    tick_fixed = 1'b0;
    // LEVEL above MAX_LEN clamps to all entries
    issue_start(1'b0, 12);
    wait_idle();
    chk("idx_after_clamp", 32'(bus.idx_o), 32'd7);
    // START while busy is ignored
    issue_start(1'b0, 4);
    wait_show(1);
    @(negedge clk);
    bus.start_i = 1'b1; bus.new_seq_i = 1'b1; bus.level_i = 4'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_idle();
    sweep_rd("rd_after_ignored_start");
    // ABORT in the gap after step 1
    issue_start(1'b0, 5);
    wait_show(1);
    n = 0;
    while (bus.leds_o != 8'h00 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("abort_leds", 32'(bus.leds_o), 32'd0);
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    chk("abort_done", 32'(bus.done_o), 32'd0);
    exp_q.delete();
    repeat (40) @(negedge clk);
    // asynchronous reset mid-show
    issue_start(1'b1, 6);
    wait_show(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_leds", 32'(bus.leds_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_idx", 32'(bus.idx_o), 32'd0);
    exp_q.delete();
    m_lfsr = 8'hA5;
    for (int i = 0; i < MAX_LEN; i++) m_mem[i] = '0;
    sweep_rd("arst_rd");
    @(negedge clk);
    rst_n = 1'b1;
    issue_start(1'b1, 4);
    wait_idle();
    sweep_rd("rd_after_rst_regen");
    // randomized runs
    for (int r = 0; r < 12; r++) begin
      issue_start(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      wait_idle();
    end
    sweep_rd("rd_final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/seq_player.md
Name: seq_player

Overview:
- Challenge side of the memory game: generates a pseudorandom pattern sequence and plays it on the LEDs one step at a time for the player to reproduce.
- Holds the sequence in an internal pattern memory. The checker reads it back through a combinational read port.
- Runs on the divided game clock. Step timing comes from a slow TICK enable strobe.

Parameters:
- MAX_LEN, 8, number of pattern-memory entries and maximum playable length (power of 2, ≤ 16)
- ON_TICKS, 4, TICK strobes each pattern stays lit
- OFF_TICKS, 2, TICK strobes of blank LEDs between patterns
- SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
- CLK  input  1  game clock
- RST  input  1  asynchronous, active-low reset
- START  input  1  one-cycle request to begin playback; ignored while BUSY=1
- NEW_SEQ  input  1  sampled with START: 1 = regenerate memory before playing, 0 = replay stored sequence
- LEVEL  input  4  number of steps to play, sampled with START
- ABORT  input  1  return to IDLE immediately, no DONE
- TICK  input  1  one-cycle timing strobe
- RD_IDX  input  log2(MAX_LEN)  checker read address
- RD_PAT  output  8  mem[RD_IDX], combinational
- LEDS  output  8  pattern currently shown, active-high
- IDX  output  log2(MAX_LEN)  step currently shown
- BUSY  output  1  high in every state except IDLE
- DONE  output  1  one-cycle pulse when playback completes

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; LEDS=0, IDX=0, BUSY=0, DONE=0.
  - All memory entries=0; LFSR=SEED; step counters=0.
  - Applies at any point, including mid-playback.
- LEVEL handling: latched into len on the accepted START. 0 is treated as 1; values > MAX_LEN are clamped to MAX_LEN.
- LFSR: 8-bit Fibonacci, shifts left; feedback bit = q[7]^q[5]^q[4]^q[3] enters at bit 0. It advances only in GEN. From SEED=A5 it produces A5, 4A, 95, 2A, ...
- States:
  - IDLE: LEDS=0. On START go to GEN if NEW_SEQ=1, else to SHOW with IDX=0.
  - GEN: each clock writes mem[wptr]=LFSR, advances the LFSR and increments wptr. All MAX_LEN entries are always written, taking MAX_LEN clocks. After the last write go to SHOW with IDX=0. LEDS=0 during GEN.
  - SHOW: LEDS=mem[IDX], registered, valid from the first cycle in SHOW. Counts TICK strobes; on the clock of the ON_TICKS-th TICK go to GAP.
  - GAP: LEDS=0. Counts TICK strobes; on the OFF_TICKS-th TICK:
    - if IDX==len-1, go to FIN;
    - otherwise IDX+1 and go to SHOW.
  - FIN: DONE=1 for exactly one cycle, LEDS=0, then IDLE. IDX holds len-1 until the next START.
- Tick counting: the tick counter clears on every state entry. A TICK coinciding with the state-entry clock is not counted.
- START while BUSY: ignored, with no effect on len, NEW_SEQ or memory.
- ABORT:
  - in any non-IDLE state: next clock goes to IDLE, LEDS=0, DONE stays 0.
  - during GEN: entries already written keep their new values.
  - ABORT has priority over START in the same cycle.
- Replay (NEW_SEQ=0): plays existing memory contents unchanged; the LFSR does not advance.
- RD_PAT: reads the memory at any time. A read during GEN of the entry being written returns the old value.

Test Plan:
- Reset, then START with NEW_SEQ=1 and LEVEL=3, TICK every 4 clocks → GEN lasts 8 clocks. LEDS then shows A5 for 4 ticks, 00 for 2 ticks, 4A, 00, 95, 00. DONE pulses once; BUSY drops on the same clock as DONE falls.
- After the first scenario, RD_IDX sweeps 0..3 → RD_PAT reads A5, 4A, 95, 2A.
- START with NEW_SEQ=0 and LEVEL=0 → only A5 is shown (clamped to 1 step), LFSR unchanged. A second START with NEW_SEQ=1 writes mem[0]=the LFSR value that followed the 8th entry, not A5.
- LEVEL=12 with MAX_LEN=8 → exactly 8 steps played, IDX ends at 7.
- START pulsed again mid-SHOW → no restart, sequence continues. ABORT mid-GAP → LEDS=0 and BUSY=0 next clock, no DONE pulse.
- RST driven low mid-SHOW, asynchronously between clock edges → LEDS, BUSY and IDX clear immediately and memory reads 0. A new NEW_SEQ=1 run reproduces A5, 4A, ...
